// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin into a clean pressed level with press/release/auto-repeat pulses.
// Latency: a raw edge captured at edge k shows up after edge k+2+DEBOUNCE_CYCLES; no backpressure, all outputs registered.
module button_debouncer #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic vga_clock_i,
    input  logic reset_i,
    input  logic button_raw_i,
    output logic button_level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_pulse_o
);

    localparam int   CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   RCNT_W = $clog2(RMAX + 1);
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LOAD  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LOAD = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        UP           = 2'd0,
        CONFIRM_DOWN = 2'd1,
        DOWN         = 2'd2,
        CONFIRM_UP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic               s1_q, s2_q;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               repeat_q, repeat_d;
    logic               s;

    // Synchronised input, normalised so 1 always means pressed.
    assign s = s2_q ^ RAW_IDLE;

    always_ff @(posedge vga_clock_i) begin
        if (reset_i) begin
            s1_q      <= RAW_IDLE;
            s2_q      <= RAW_IDLE;
            state_q   <= UP;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= button_raw_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            UP: begin
                rcnt_d = '0;
                if (s) begin
                    state_d = CONFIRM_DOWN;
                    cnt_d   = '0;
                end
            end
            CONFIRM_DOWN: begin
                if (!s) begin
                    state_d = UP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rcnt_d  = DELAY_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                // Repeat timer only advances while firmly held; it freezes in CONFIRM_UP.
                if (rcnt_q == '0) begin
                    repeat_d = (REPEAT_EN != 0);
                    rcnt_d   = PERIOD_LOAD;
                end else begin
                    rcnt_d = rcnt_q - RCNT_W'(1);
                end
                if (!s) begin
                    state_d = CONFIRM_UP;
                    cnt_d   = '0;
                end
            end
            CONFIRM_UP: begin
                if (s) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = UP;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = UP;
            end
        endcase
    end

    assign button_level_o = level_q;
    assign press_o        = press_q;
    assign release_o      = release_q;
    assign repeat_pulse_o = repeat_q;

endmodule
